// File: rtl/simon_input_conditioner.sv
// simon_input_conditioner
//   Conditions the raw board inputs for the Simon core. It synchronizes the
//   button and switches, debounces them, and turns button activity into
//   strobes. A short press gives an advance strobe when the button is
//   released. A press held for LONG_CYCLES gives a game-reset strobe and no
//   advance. The pattern snapshot stays frozen from the moment a press is
//   accepted, so it is still valid when adv_pulse fires.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous active-high reset
//   btn_raw    in   1      raw advance button (async, 1 = pressed)
//   level_raw  in   1      raw level switch (async)
//   pat_raw    in   PAT_W  raw pattern switches (async)
//   adv_pulse  out  1      one-cycle strobe per accepted short press
//   game_rst   out  1      one-cycle strobe when a press reaches LONG_CYCLES
//   level      out  1      debounced level switch
//   pattern    out  PAT_W  debounced pattern, frozen while the button is held
//   busy       out  1      button FSM is not idle
module simon_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LONG_CYCLES     = 2000000,
  parameter int PAT_W           = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_raw,
  input  logic             level_raw,
  input  logic [PAT_W-1:0] pat_raw,
  output logic             adv_pulse,
  output logic             game_rst,
  output logic             level,
  output logic [PAT_W-1:0] pattern,
  output logic             busy
);

  localparam int SW_W = PAT_W + 1;                    // {level, pattern}
  localparam int IN_W = SW_W + 1;                     // {btn, level, pattern}
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW   = $clog2(LONG_CYCLES + 1);

  localparam logic [DW-1:0] DEB_ONE   = DW'(1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_PRESS_WAIT   = 3'd1;
  localparam logic [2:0] ST_HELD         = 3'd2;
  localparam logic [2:0] ST_RELEASE_WAIT = 3'd3;
  localparam logic [2:0] ST_LONG         = 3'd4;

  // ------------------------------------------------------------------
  // Two-flop synchronizers, one per raw input bit
  // ------------------------------------------------------------------
  logic [IN_W-1:0] raw_vec;
  logic [IN_W-1:0] sync_vec;

  assign raw_vec = {btn_raw, level_raw, pat_raw};

  genvar gi;
  generate
    for (gi = 0; gi < IN_W; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= raw_vec[gi];
          sync_reg <= meta_reg;
        end
      end

      assign sync_vec[gi] = sync_reg;
    end
  endgenerate

  logic            btn_s;
  logic [SW_W-1:0] sw_s;

  assign btn_s = sync_vec[IN_W-1];
  assign sw_s  = sync_vec[SW_W-1:0];

  // ------------------------------------------------------------------
  // Shared switch filter: the whole {level, pattern} word must hold one
  // value for DEBOUNCE_CYCLES consecutive samples before it is accepted.
  // ------------------------------------------------------------------
  logic [SW_W-1:0] cand_reg;
  logic [SW_W-1:0] sw_stable_reg;
  logic [DW-1:0]   sw_cnt_reg;
  logic [DW-1:0]   sw_cnt_next;
  logic            sw_load;

  always_comb begin
    sw_cnt_next = sw_cnt_reg;
    if (sw_s != cand_reg) begin
      sw_cnt_next = '0;
    end else if (sw_cnt_reg != DEB_LAST) begin
      sw_cnt_next = sw_cnt_reg + DEB_ONE;
    end
  end

  assign sw_load = (sw_s == cand_reg) && (sw_cnt_next == DEB_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_reg      <= '0;
      sw_cnt_reg    <= '0;
      sw_stable_reg <= '0;
    end else begin
      cand_reg   <= sw_s;
      sw_cnt_reg <= sw_cnt_next;
      if (sw_load) begin
        sw_stable_reg <= cand_reg;
      end
    end
  end

  // ------------------------------------------------------------------
  // Button FSM
  //   deb_cnt  : consecutive samples of the level being debounced. The
  //              sample that causes entry into PRESS_WAIT / RELEASE_WAIT
  //              is already the first one, so those entries load 1.
  //   hold_cnt : confirmed-press cycles; survives a HELD <-> RELEASE_WAIT
  //              bounce so a bouncy long press still reaches game_rst.
  // ------------------------------------------------------------------
  logic [2:0]    state_reg, state_next;
  logic [DW-1:0] deb_cnt_reg, deb_cnt_next;
  logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
  logic          adv_next;
  logic          grst_next;
  logic          pat_load;
  logic          adv_pulse_reg;
  logic          game_rst_reg;
  logic [PAT_W-1:0] pattern_reg;

  always_comb begin
    state_next    = state_reg;
    deb_cnt_next  = deb_cnt_reg;
    hold_cnt_next = hold_cnt_reg;
    adv_next      = 1'b0;
    grst_next     = 1'b0;
    pat_load      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (btn_s) begin
          state_next    = ST_PRESS_WAIT;
          deb_cnt_next  = DEB_ONE;
          hold_cnt_next = '0;
        end
      end

      ST_PRESS_WAIT: begin
        if (!btn_s) begin
          state_next   = ST_IDLE;
          deb_cnt_next = '0;
        end else if (deb_cnt_reg == DEB_LAST) begin
          state_next    = ST_HELD;
          deb_cnt_next  = '0;
          hold_cnt_next = '0;
          pat_load      = 1'b1;
        end else begin
          deb_cnt_next = deb_cnt_reg + DEB_ONE;
        end
      end

      ST_HELD: begin
        if (!btn_s) begin
          state_next   = ST_RELEASE_WAIT;
          deb_cnt_next = DEB_ONE;
        end else if (hold_cnt_reg == HOLD_LAST) begin
          state_next    = ST_LONG;
          grst_next     = 1'b1;
          deb_cnt_next  = '0;
          hold_cnt_next = '0;
        end else begin
          hold_cnt_next = hold_cnt_reg + HOLD_ONE;
        end
      end

      ST_RELEASE_WAIT: begin
        if (btn_s) begin
          // release bounce: back to HELD with the press count intact
          state_next   = ST_HELD;
          deb_cnt_next = '0;
        end else if (deb_cnt_reg == DEB_LAST) begin
          state_next    = ST_IDLE;
          adv_next      = 1'b1;
          deb_cnt_next  = '0;
          hold_cnt_next = '0;
        end else begin
          deb_cnt_next = deb_cnt_reg + DEB_ONE;
        end
      end

      ST_LONG: begin
        // hold_cnt stays put here; only the release is debounced
        if (btn_s) begin
          deb_cnt_next = '0;
        end else if (deb_cnt_reg == DEB_LAST) begin
          state_next   = ST_IDLE;
          deb_cnt_next = '0;
        end else begin
          deb_cnt_next = deb_cnt_reg + DEB_ONE;
        end
      end

      default: begin
        state_next    = ST_IDLE;
        deb_cnt_next  = '0;
        hold_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      deb_cnt_reg   <= '0;
      hold_cnt_reg  <= '0;
      adv_pulse_reg <= 1'b0;
      game_rst_reg  <= 1'b0;
      pattern_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      deb_cnt_reg   <= deb_cnt_next;
      hold_cnt_reg  <= hold_cnt_next;
      adv_pulse_reg <= adv_next;
      game_rst_reg  <= grst_next;
      // pattern tracks the filter only while idle; the snapshot taken on
      // HELD entry is what the core sees when adv_pulse arrives
      if ((state_reg == ST_IDLE) || pat_load) begin
        pattern_reg <= sw_stable_reg[PAT_W-1:0];
      end
    end
  end

  assign adv_pulse = adv_pulse_reg;
  assign game_rst  = game_rst_reg;
  assign level     = sw_stable_reg[PAT_W];
  assign pattern   = pattern_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule
